// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared encodings and decode helpers for the MEM-stage access unit
package mem_access_unit_pkg;

    localparam int DATAWIDTH = 32;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } mau_state_t;

    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_load);
        if (is_load)
            return !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
        return !(f3 == F3_SB || f3 == F3_SH || f3 == F3_SW);
    endfunction

    // f3[1:0] is the access size for both signed and unsigned loads
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory request/response bus between the access unit and memory
interface mem_access_unit_if #(
    parameter int DW = mem_access_unit_pkg::DATAWIDTH
);
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [3:0]    dmem_wstrb;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_gnt;
    logic          dmem_rvalid;
    logic [DW-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane replication/strobes and load byte/half extract with extension
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int DW = DATAWIDTH
) (
    input  logic [2:0]    st_func3,
    input  logic [1:0]    st_addr_lo,
    input  logic [DW-1:0] st_data,
    output logic [3:0]    wstrb,
    output logic [DW-1:0] wdata,
    input  logic [2:0]    ld_func3,
    input  logic [1:0]    ld_addr_lo,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] ld_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        wstrb = 4'hF;
        wdata = st_data;
        case (st_func3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << st_addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                wstrb = 4'b0011 << st_addr_lo;
                wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_v = rdata[7:0];
        case (ld_addr_lo)
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            2'd3:    byte_v = rdata[31:24];
            default: ;
        endcase
        half_v = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // func3[2] selects zero extension (lbu/lhu)
    always_comb begin
        ld_data = rdata;
        case (ld_func3[1:0])
            2'b00:   ld_data = ld_func3[2] ? {{(DW-8){1'b0}}, byte_v}
                                           : {{(DW-8){byte_v[7]}}, byte_v};
            2'b01:   ld_data = ld_func3[2] ? {{(DW-16){1'b0}}, half_v}
                                           : {{(DW-16){half_v[15]}}, half_v};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access FSM gating the EX/MEM release
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DW      = DATAWIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stage_valid,
    input  logic          stage_fire,
    input  logic [DW-1:0] in_ALU_res,
    input  logic [DW-1:0] in_Rd_data2,
    input  logic [2:0]    in_func3,
    input  logic          in_L_type,
    input  logic          in_S_type,
    output logic          pipe_ready_go,
    output logic [DW-1:0] load_data,
    output logic          misalign,
    output logic          bus_err,
    mem_access_unit_if.master dmem
);

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    mau_state_t    state_q, state_d;
    logic [15:0]   cnt_q;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    wstrb_q;
    logic          we_q;
    logic [2:0]    func3_q;
    logic [1:0]    lo_q;
    logic [DW-1:0] load_data_q;
    logic          bus_err_q;

    logic          mem_op;
    logic          is_store;
    logic          req_err;
    logic          capture;
    logic          timeout_hit;
    logic          timeout_fire;
    logic [3:0]    lane_wstrb;
    logic [DW-1:0] lane_wdata;
    logic [DW-1:0] lane_ld;

    assign mem_op   = in_L_type | in_S_type;
    assign is_store = in_S_type & ~in_L_type;
    assign req_err  = f3_illegal(in_func3, in_L_type) | addr_misaligned(in_func3, in_ALU_res[1:0]);
    assign capture  = (state_q == ST_IDLE) && stage_valid && mem_op && !req_err && !stage_fire;

    assign timeout_hit  = (TIMEOUT != 0) && (cnt_q == TMO - 16'd1);
    // a grant or response arriving on the last allowed cycle still wins
    assign timeout_fire = timeout_hit &&
                          (((state_q == ST_REQ)  && !dmem.dmem_gnt) ||
                           ((state_q == ST_RESP) && !dmem.dmem_rvalid));

    mem_lane_align #(.DW(DW)) u_lane (
        .st_func3   (in_func3),
        .st_addr_lo (in_ALU_res[1:0]),
        .st_data    (in_Rd_data2),
        .wstrb      (lane_wstrb),
        .wdata      (lane_wdata),
        .ld_func3   (func3_q),
        .ld_addr_lo (lo_q),
        .rdata      (dmem.dmem_rdata),
        .ld_data    (lane_ld)
    );

    always_comb begin
        state_d       = state_q;
        pipe_ready_go = 1'b0;
        misalign      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stage_valid) begin
                    if (!mem_op) begin
                        pipe_ready_go = 1'b1;
                    end else if (req_err) begin
                        misalign      = 1'b1;
                        pipe_ready_go = 1'b1;
                    end else if (!stage_fire) begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dmem.dmem_gnt)   state_d = ST_RESP;
                else if (timeout_hit) state_d = ST_DONE;
            end
            ST_RESP: begin
                if (dmem.dmem_rvalid) state_d = ST_DONE;
                else if (timeout_hit)  state_d = ST_DONE;
            end
            ST_DONE: begin
                pipe_ready_go = 1'b1;
                if (stage_fire) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            we_q        <= 1'b0;
            func3_q     <= '0;
            lo_q        <= '0;
            load_data_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= ((state_q == ST_REQ) || (state_q == ST_RESP)) ? cnt_q + 16'd1 : 16'd0;
            if (capture) begin
                addr_q  <= {in_ALU_res[DW-1:2], 2'b00};
                wdata_q <= lane_wdata;
                wstrb_q <= is_store ? lane_wstrb : 4'h0;
                we_q    <= is_store;
                func3_q <= in_func3;
                lo_q    <= in_ALU_res[1:0];
            end
            if ((state_q == ST_RESP) && dmem.dmem_rvalid)
                load_data_q <= we_q ? '0 : lane_ld;
            else if (timeout_fire)
                load_data_q <= '0;
            if (timeout_fire)
                bus_err_q <= 1'b1;
            else if ((state_q == ST_DONE) && stage_fire)
                bus_err_q <= 1'b0;
        end
    end

    assign dmem.dmem_req   = (state_q == ST_REQ);
    assign dmem.dmem_we    = (state_q == ST_REQ) && we_q;
    assign dmem.dmem_wstrb = (state_q == ST_REQ) ? wstrb_q : 4'h0;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign load_data       = load_data_q;
    assign bus_err         = bus_err_q;

endmodule
